// File: rtl/register_op_sequencer.sv
// Command sequencer for the 12-entry register bank. Accepts one register
// command per valid/ready handshake and drives the bank load, op select and
// data inputs. Multi-bit shifts run as a series of single-bit bank ops, one
// per clock, with the target register fed back into the bank data input.
module register_op_sequencer #(
    parameter int NREG  = 12,
    parameter int W     = 20,
    parameter int CNT_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [3:0]          cmd_dst,
    input  logic [3:0]          cmd_src,
    input  logic [CNT_W-1:0]    cmd_cnt,
    input  logic [W-1:0]        cmd_imm,
    input  logic [NREG*W-1:0]   reg_q,
    output logic [NREG-1:0]     reg_load,
    output logic [9:0]          reg_j,
    output logic [W-1:0]        reg_i,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_NOT   = 3'd1;
    localparam logic [2:0] OP_SHR   = 3'd2;
    localparam logic [2:0] OP_SHL   = 3'd3;
    localparam logic [2:0] OP_MOVE  = 3'd4;

    // Source of the bank data input while a command executes
    localparam logic [1:0] ISEL_ZERO = 2'd0;
    localparam logic [1:0] ISEL_IMM  = 2'd1;
    localparam logic [1:0] ISEL_DST  = 2'd2;
    localparam logic [1:0] ISEL_SRC  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NREG-1:0]    r_load;
    logic [1:0]         r_j;
    logic [1:0]         r_isel;
    logic [3:0]         r_dst;
    logic [3:0]         r_src;
    logic [W-1:0]       r_imm;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_illegal;
    logic               w_is_shift;
    logic [CNT_W-1:0]   w_cnt_clamped;
    logic [W-1:0]       w_dst_q;
    logic [W-1:0]       w_src_q;

    // One-hot decode of a register index; indices >= NREG give all zeros
    function automatic logic [NREG-1:0] f_onehot(input logic [3:0] idx);
        logic [NREG-1:0] v;
        v = {NREG{1'b0}};
        for (int k = 0; k < NREG; k++) begin
            v[k] = (idx == 4'(k));
        end
        return v;
    endfunction

    // Command legality check and shift-count clamping for the incoming command
    always_comb begin
        w_is_shift    = (cmd_op == OP_SHR) || (cmd_op == OP_SHL);
        w_illegal     = (cmd_op > OP_MOVE) ||
                        (cmd_dst >= 4'(NREG)) ||
                        ((cmd_op == OP_MOVE) && (cmd_src >= 4'(NREG)));
        if (cmd_cnt > CNT_W'(W)) begin
            w_cnt_clamped = CNT_W'(W);
        end else begin
            w_cnt_clamped = cmd_cnt;
        end
    end

    // Select the latched destination and source registers out of the bank bus
    always_comb begin
        w_dst_q = {W{1'b0}};
        w_src_q = {W{1'b0}};
        for (int k = 0; k < NREG; k++) begin
            w_dst_q = w_dst_q | ((r_dst == 4'(k)) ? reg_q[k*W +: W] : {W{1'b0}});
            w_src_q = w_src_q | ((r_src == 4'(k)) ? reg_q[k*W +: W] : {W{1'b0}});
        end
    end

    // Bank data input: the only path from an input (reg_q) to an output
    always_comb begin
        case (r_isel)
            ISEL_IMM: reg_i = r_imm;
            ISEL_DST: reg_i = w_dst_q;
            ISEL_SRC: reg_i = w_src_q;
            default:  reg_i = {W{1'b0}};
        endcase
    end

    // Sequencer FSM with all control outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_load  <= {NREG{1'b0}};
            r_j     <= 2'b00;
            r_isel  <= ISEL_ZERO;
            r_dst   <= 4'd0;
            r_src   <= 4'd0;
            r_imm   <= {W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_load  <= {NREG{1'b0}};
                    r_j     <= 2'b00;
                    r_isel  <= ISEL_ZERO;
                    if (cmd_valid && r_ready) begin
                        r_dst <= cmd_dst;
                        r_src <= cmd_src;
                        r_imm <= cmd_imm;
                        if (w_illegal) begin
                            // Rejected: stay ready, flag for one cycle
                            r_err <= 1'b1;
                        end else if (w_is_shift && (cmd_cnt == {CNT_W{1'b0}})) begin
                            // Zero-length shift retires without touching the bank
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_EXEC;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                            r_load  <= f_onehot(cmd_dst);
                            if (w_is_shift) begin
                                r_cnt <= w_cnt_clamped;
                            end else begin
                                r_cnt <= CNT_W'(1);
                            end
                            case (cmd_op)
                                OP_WRITE: begin r_j <= 2'b00; r_isel <= ISEL_IMM; end
                                OP_NOT:   begin r_j <= 2'b01; r_isel <= ISEL_DST; end
                                OP_SHR:   begin r_j <= 2'b10; r_isel <= ISEL_DST; end
                                OP_SHL:   begin r_j <= 2'b11; r_isel <= ISEL_DST; end
                                OP_MOVE:  begin r_j <= 2'b00; r_isel <= ISEL_SRC; end
                                default:  begin r_j <= 2'b00; r_isel <= ISEL_ZERO; end
                            endcase
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_load  <= {NREG{1'b0}};
                        r_j     <= 2'b00;
                        r_isel  <= ISEL_ZERO;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_load  <= {NREG{1'b0}};
                    r_j     <= 2'b00;
                    r_isel  <= ISEL_ZERO;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign reg_load  = r_load;
    assign reg_j     = {8'b0000_0000, r_j};
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
